// File: rtl/frame_writer_pkg.sv
// rtl/frame_writer_pkg.sv - shared types and constants for the frame writer
package frame_pkg;

   localparam int DEF_COOR_WIDTH = 12;
   localparam int DEF_HSIZE      = 720;
   localparam int DEF_VSIZE      = 540;
   localparam int DEF_RENDER_LAT = 2;

   typedef logic [DEF_COOR_WIDTH-1:0] coord_t;
   typedef logic [11:0]               pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fw_state_e;

   // Magenta marks a pixel the renderer failed to deliver
   localparam pixel_t UNDERFLOW_COLOR = 12'hF0F;

endpackage

// File: rtl/frame_writer_coord_delay_line.sv
// rtl/frame_writer_coord_delay_line.sv - fixed-depth delay of {x, y, valid} matching renderer latency
module coord_delay_line #(
   parameter int W     = 12,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic         in_valid,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_y,
   output logic         out_valid
);

   logic [W-1:0] x_q [DEPTH];
   logic [W-1:0] x_d [DEPTH];
   logic [W-1:0] y_q [DEPTH];
   logic [W-1:0] y_d [DEPTH];
   logic         v_q [DEPTH];
   logic         v_d [DEPTH];

   // Next state: stage 0 takes the live request, every other stage takes its predecessor
   always_comb begin
      x_d[0] = in_x;
      y_d[0] = in_y;
      v_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
         x_d[i] = x_q[i-1];
         y_d[i] = y_q[i-1];
         v_d[i] = v_q[i-1];
      end
   end

   // Shift register with synchronous clear so a reset discards in-flight requests
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            v_q[i] <= 1'b0;
         end
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         v_q <= v_d;
      end
   end

   assign out_x     = x_q[DEPTH-1];
   assign out_y     = y_q[DEPTH-1];
   assign out_valid = v_q[DEPTH-1];

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - raster sweep producer realigning renderer pixels to RAM writes (option FRAME_WRITER_OVERRUN_EN)
module frame_writer
   import frame_pkg::*;
#(
   parameter int COOR_WIDTH = DEF_COOR_WIDTH,
   parameter int HSIZE      = DEF_HSIZE,
   parameter int VSIZE      = DEF_VSIZE,
   parameter int RENDER_LAT = DEF_RENDER_LAT
) (
   input  logic                  clk_wr,
   input  logic                  rst_n,
   input  logic                  frame_start,
   output logic [COOR_WIDTH-1:0] req_x,
   output logic [COOR_WIDTH-1:0] req_y,
   output logic                  req_valid,
   input  pixel_t                pix_data,
   input  logic                  pix_valid,
   output logic [COOR_WIDTH-1:0] write_x,
   output logic [COOR_WIDTH-1:0] write_y,
   output pixel_t                input_pixel,
   output logic                  write_valid,
   output logic                  write_finished,
   output logic                  busy,
   output logic                  err_underflow
`ifdef FRAME_WRITER_OVERRUN_EN
   ,
   output logic [7:0]            overrun_cnt
`endif
);

   if (HSIZE >= 2**COOR_WIDTH || VSIZE >= 2**COOR_WIDTH) begin : g_bad_size
      $error("frame_writer: HSIZE/VSIZE do not fit in COOR_WIDTH");
   end
   if (RENDER_LAT < 1 || RENDER_LAT > 8) begin : g_bad_lat
      $error("frame_writer: RENDER_LAT must be 1..8");
   end

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SWEEP = SWEEP;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   localparam logic [COOR_WIDTH-1:0] X_LAST     = COOR_WIDTH'(HSIZE - 1);
   localparam logic [COOR_WIDTH-1:0] Y_LAST     = COOR_WIDTH'(VSIZE - 1);
   localparam logic [3:0]            DRAIN_LAST = 4'(RENDER_LAT);

   logic [1:0]            state_q, state_d;
   logic [COOR_WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [3:0]            drain_q, drain_d;
   logic [COOR_WIDTH-1:0] wx_q, wx_d, wy_q, wy_d;
   pixel_t                pix_q, pix_d;
   logic                  wv_q, wv_d;
   logic                  err_q, err_d;

   logic [COOR_WIDTH-1:0] dl_x, dl_y;
   logic                  dl_valid;

   assign req_valid = (state_q == ST_SWEEP);
   assign req_x     = x_q;
   assign req_y     = y_q;

   coord_delay_line #(
      .W     (COOR_WIDTH),
      .DEPTH (RENDER_LAT)
   ) u_delay (
      .clk       (clk_wr),
      .rst_n     (rst_n),
      .in_x      (x_q),
      .in_y      (y_q),
      .in_valid  (req_valid),
      .out_x     (dl_x),
      .out_y     (dl_y),
      .out_valid (dl_valid)
   );

   // Sweep FSM plus write-side capture of pixels aligned with their delayed coordinates
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      drain_d = drain_q;
      wx_d    = wx_q;
      wy_d    = wy_q;
      pix_d   = pix_q;
      wv_d    = 1'b0;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d = ST_SWEEP;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ST_SWEEP: begin
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  y_d     = '0;
                  drain_d = '0;
                  state_d = ST_DRAIN;
               end else begin
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Last request still travels RENDER_LAT cycles plus the write register
            if (drain_q == DRAIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (dl_valid) begin
         wx_d = dl_x;
         wy_d = dl_y;
         wv_d = 1'b1;
         if (pix_valid) begin
            pix_d = pix_data;
         end else begin
            pix_d = UNDERFLOW_COLOR;
            err_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_wr) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         drain_q <= '0;
         wx_q    <= '0;
         wy_q    <= '0;
         pix_q   <= '0;
         wv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         drain_q <= drain_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         pix_q   <= pix_d;
         wv_q    <= wv_d;
         err_q   <= err_d;
      end
   end

   assign write_x        = wx_q;
   assign write_y        = wy_q;
   assign input_pixel    = pix_q;
   assign write_valid    = wv_q;
   assign write_finished = (state_q == ST_DONE);
   assign busy           = (state_q != ST_IDLE);
   assign err_underflow  = err_q;

`ifdef FRAME_WRITER_OVERRUN_EN
   logic [7:0] ovr_q, ovr_d;

   // Count frame_start pulses dropped because a frame is in flight
   always_comb begin
      ovr_d = ovr_q;
      if (frame_start && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 1'b1;
      end
   end

   // Overrun counter register
   always_ff @(posedge clk_wr) begin
      if (!rst_n) begin
         ovr_q <= '0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - directed self-checking bench for frame_writer at RENDER_LAT 2, 1 and 8
`timescale 1ns/1ps
module tb_frame_writer;

   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fs_all = 1'b0;
   logic fs_x = 1'b0;
   logic kill = 1'b0;

   logic        fs_in   [ND];
   logic [11:0] req_x   [ND];
   logic [11:0] req_y   [ND];
   logic        req_v   [ND];
   logic [11:0] pix_d   [ND];
   logic        pix_v   [ND];
   logic [11:0] wx      [ND];
   logic [11:0] wy      [ND];
   logic [11:0] wpix    [ND];
   logic        wv      [ND];
   logic        wf      [ND];
   logic        busy    [ND];
   logic        err     [ND];
`ifdef FRAME_WRITER_OVERRUN_EN
   logic [7:0]  ovr     [ND];
`endif

   int n_pass = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 8;
      logic [11:0] hx [8];
      logic [11:0] hy [8];
      logic        hv [8];

      assign fs_in[g] = fs_all | ((g == 0) ? fs_x : 1'b0);

      always @(posedge clk) begin
         hx[0] <= req_x[g];
         hy[0] <= req_y[g];
         hv[0] <= req_v[g];
         for (int j = 1; j < 8; j++) begin
            hx[j] <= hx[j-1];
            hy[j] <= hy[j-1];
            hv[j] <= hv[j-1];
         end
      end

      assign pix_v[g] = hv[L-1] & ~(kill && hx[L-1] == 12'd3 && hy[L-1] == 12'd1);
      assign pix_d[g] = {hx[L-1][3:0], hy[L-1][3:0], 4'h5};

      frame_writer #(
         .COOR_WIDTH (12),
         .HSIZE      (8),
         .VSIZE      (4),
         .RENDER_LAT (L)
      ) u_dut (
         .clk_wr         (clk),
         .rst_n          (rst_n),
         .frame_start    (fs_in[g]),
         .req_x          (req_x[g]),
         .req_y          (req_y[g]),
         .req_valid      (req_v[g]),
         .pix_data       (pix_d[g]),
         .pix_valid      (pix_v[g]),
         .write_x        (wx[g]),
         .write_y        (wy[g]),
         .input_pixel    (wpix[g]),
         .write_valid    (wv[g]),
         .write_finished (wf[g]),
         .busy           (busy[g]),
         .err_underflow  (err[g])
`ifdef FRAME_WRITER_OVERRUN_EN
         ,
         .overrun_cnt    (ovr[g])
`endif
      );
   end

   int lat_of [ND] = '{2, 1, 8};

   int wcnt [ND], wfirst [ND], wlast [ND], bad [ND];
   int fcnt [ND], fcyc [ND], bfall [ND], efirst [ND], edrop [ND];
   int lastx [ND], lasty [ND], maxx [ND], maxy [ND];
   logic [11:0] killpix [ND];
   bit zero_ok [ND];
   bit prev_busy [ND];

   // Drives one run of n cycles (cycle 0 = now) and records per-DUT observations
   task automatic run(input int n, input int c_start, input int c_x1, input int c_x2,
                      input int c_rst, input bit kill_en);
      int ex, ey;
      logic [11:0] ep;
      for (int i = 0; i < ND; i++) begin
         wcnt[i] = 0; wfirst[i] = -1; wlast[i] = -1; bad[i] = 0;
         fcnt[i] = 0; fcyc[i] = -1; bfall[i] = -1; efirst[i] = -1; edrop[i] = 0;
         lastx[i] = -1; lasty[i] = -1; maxx[i] = 0; maxy[i] = 0;
         killpix[i] = 12'h000; zero_ok[i] = 1'b0; prev_busy[i] = 1'b0;
      end
      kill = kill_en;
      for (int k = 0; k <= n; k++) begin
         for (int i = 0; i < ND; i++) begin
            if (k == c_rst + 1)
               zero_ok[i] = (wx[i] == 0 && wy[i] == 0 && wpix[i] == 0 && wv[i] == 0 &&
                             wf[i] == 0 && busy[i] == 0 && err[i] == 0 &&
                             req_x[i] == 0 && req_y[i] == 0 && req_v[i] == 0);
            if (wv[i]) begin
               ex = wcnt[i] % 8;
               ey = wcnt[i] / 8;
               ep = 12'((ex << 8) | (ey << 4) | 5);
               if (kill_en && ex == 3 && ey == 1) begin
                  ep = 12'hF0F;
                  killpix[i] = wpix[i];
               end
               if (int'(wx[i]) != ex || int'(wy[i]) != ey || wpix[i] !== ep) bad[i]++;
               if (wfirst[i] < 0) wfirst[i] = k;
               wlast[i] = k;
               lastx[i] = int'(wx[i]);
               lasty[i] = int'(wy[i]);
               if (int'(wx[i]) > maxx[i]) maxx[i] = int'(wx[i]);
               if (int'(wy[i]) > maxy[i]) maxy[i] = int'(wy[i]);
               wcnt[i]++;
            end
            if (wf[i]) begin
               fcnt[i]++;
               fcyc[i] = k;
            end
            if (k > 0 && prev_busy[i] && !busy[i] && bfall[i] < 0) bfall[i] = k;
            prev_busy[i] = busy[i];
            if (err[i] && efirst[i] < 0) efirst[i] = k;
            if (!err[i] && efirst[i] >= 0) edrop[i] = 1;
         end
         fs_all = (k == c_start);
         fs_x   = (k == c_x1 || k == c_x2);
         rst_n  = !(k == c_rst);
         @(posedge clk);
         #1;
      end
      fs_all = 1'b0;
      fs_x   = 1'b0;
      rst_n  = 1'b1;
      kill   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (req_v[0] !== 1'b0) $display("FAIL reset_req_valid got %b want 0", req_v[0]); else n_pass++;
      n_chk++; if (busy[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", busy[0]); else n_pass++;
      n_chk++; if (wv[0] !== 1'b0) $display("FAIL reset_write_valid got %b want 0", wv[0]); else n_pass++;
      n_chk++; if (wf[0] !== 1'b0) $display("FAIL reset_write_finished got %b want 0", wf[0]); else n_pass++;
      n_chk++; if (err[0] !== 1'b0) $display("FAIL reset_err got %b want 0", err[0]); else n_pass++;
      n_chk++; if (wpix[0] !== 12'h000) $display("FAIL reset_input_pixel got %h want 000", wpix[0]); else n_pass++;
      n_chk++; if (wx[0] !== 12'd0 || wy[0] !== 12'd0) $display("FAIL reset_write_xy got %0d,%0d want 0,0", wx[0], wy[0]); else n_pass++;
      n_chk++; if (busy[1] !== 1'b0 || busy[2] !== 1'b0) $display("FAIL reset_busy_lat18 got %b%b want 00", busy[1], busy[2]); else n_pass++;
`ifdef FRAME_WRITER_OVERRUN_EN
      n_chk++; if (ovr[0] !== 8'd0) $display("FAIL reset_overrun got %0d want 0", ovr[0]); else n_pass++;
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_frame_timing();
      run(50, 0, -1, -1, -1, 1'b0);
      for (int i = 0; i < ND; i++) begin
         n_chk++; if (wcnt[i] != 32) $display("FAIL timing_count[L%0d] got %0d want 32", lat_of[i], wcnt[i]); else n_pass++;
         n_chk++; if (wfirst[i] != lat_of[i] + 2) $display("FAIL timing_first[L%0d] got %0d want %0d", lat_of[i], wfirst[i], lat_of[i] + 2); else n_pass++;
         n_chk++; if (wlast[i] != lat_of[i] + 33) $display("FAIL timing_last[L%0d] got %0d want %0d", lat_of[i], wlast[i], lat_of[i] + 33); else n_pass++;
         n_chk++; if (bad[i] != 0) $display("FAIL timing_align[L%0d] got %0d bad writes want 0", lat_of[i], bad[i]); else n_pass++;
         n_chk++; if (fcnt[i] != 1 || fcyc[i] != lat_of[i] + 34) $display("FAIL timing_finished[L%0d] got %0d pulses at %0d want 1 at %0d", lat_of[i], fcnt[i], fcyc[i], lat_of[i] + 34); else n_pass++;
      end
      n_chk++; if (bfall[0] != 37) $display("FAIL timing_busy_fall got %0d want 37", bfall[0]); else n_pass++;
   endtask

   task automatic test_row_wrap();
      run(50, 0, -1, -1, -1, 1'b0);
      n_chk++; if (lastx[0] != 7 || lasty[0] != 3) $display("FAIL wrap_last got %0d,%0d want 7,3", lastx[0], lasty[0]); else n_pass++;
      n_chk++; if (maxx[0] != 7 || maxy[0] != 3) $display("FAIL wrap_max got %0d,%0d want 7,3", maxx[0], maxy[0]); else n_pass++;
      n_chk++; if (bad[0] != 0) $display("FAIL wrap_order got %0d bad writes want 0", bad[0]); else n_pass++;
   endtask

   task automatic test_busy_start();
      run(50, 0, 10, 36, -1, 1'b0);
      n_chk++; if (fcnt[0] != 1 || fcyc[0] != 36) $display("FAIL busy_finished got %0d pulses at %0d want 1 at 36", fcnt[0], fcyc[0]); else n_pass++;
      n_chk++; if (wcnt[0] != 32 || bad[0] != 0) $display("FAIL busy_writes got %0d writes %0d bad want 32/0", wcnt[0], bad[0]); else n_pass++;
      n_chk++; if (busy[0] !== 1'b0) $display("FAIL busy_idle_after got %b want 0", busy[0]); else n_pass++;
`ifdef FRAME_WRITER_OVERRUN_EN
      n_chk++; if (ovr[0] !== 8'd2) $display("FAIL busy_overrun got %0d want 2", ovr[0]); else n_pass++;
`endif
   endtask

   task automatic test_underflow();
      run(50, 0, -1, -1, -1, 1'b1);
      n_chk++; if (killpix[0] !== 12'hF0F) $display("FAIL uf_pixel got %h want f0f", killpix[0]); else n_pass++;
      n_chk++; if (efirst[0] != 15) $display("FAIL uf_err_cycle got %0d want 15", efirst[0]); else n_pass++;
      n_chk++; if (edrop[0] != 0) $display("FAIL uf_sticky got %0d drops want 0", edrop[0]); else n_pass++;
      n_chk++; if (bad[0] != 0 || wcnt[0] != 32) $display("FAIL uf_others got %0d bad %0d writes want 0/32", bad[0], wcnt[0]); else n_pass++;
      n_chk++; if (fcyc[0] != 36) $display("FAIL uf_finished got %0d want 36", fcyc[0]); else n_pass++;
      n_chk++; if (bad[1] != 0 || bad[2] != 0) $display("FAIL uf_lat18 got %0d,%0d bad want 0,0", bad[1], bad[2]); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      run(30, 0, -1, -1, 15, 1'b0);
      for (int i = 0; i < ND; i++) begin
         n_chk++; if (!zero_ok[i]) $display("FAIL midrst_zero[L%0d] got nonzero outputs want all 0", lat_of[i]); else n_pass++;
         n_chk++; if (fcnt[i] != 0) $display("FAIL midrst_finished[L%0d] got %0d want 0", lat_of[i], fcnt[i]); else n_pass++;
      end
      n_chk++; if (wcnt[0] != 12) $display("FAIL midrst_count got %0d want 12", wcnt[0]); else n_pass++;
      run(50, 0, -1, -1, -1, 1'b0);
      n_chk++; if (wcnt[0] != 32 || bad[0] != 0) $display("FAIL midrst_refill got %0d writes %0d bad want 32/0", wcnt[0], bad[0]); else n_pass++;
      n_chk++; if (fcnt[0] != 1 || fcyc[0] != 36) $display("FAIL midrst_refinish got %0d at %0d want 1 at 36", fcnt[0], fcyc[0]); else n_pass++;
      n_chk++; if (wfirst[0] != 4) $display("FAIL midrst_refirst got %0d want 4", wfirst[0]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frame_timing();
      test_row_wrap();
      test_busy_start();
      test_underflow();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
